// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transaction sequencer in front of a byte-level SPI master.
// Frames a command with chip select, streams one TX byte at a time and returns RX bytes.
module spi_xfer_ctrl #(
  parameter int MAX_BYTES     = 16,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int CS_GAP_CLKS   = 2,
  localparam int LEN_W        = $clog2(MAX_BYTES + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Cmd_Valid,
  input  logic [LEN_W-1:0] i_Cmd_Len,
  output logic             o_Cmd_Ready,
  input  logic             i_Abort,
  input  logic [7:0]       i_Tx_Data,
  input  logic             i_Tx_Valid,
  output logic             o_Tx_Ready,
  output logic [7:0]       o_Rx_Data,
  output logic             o_Rx_Valid,
  input  logic             i_Rx_Ready,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Aborted,
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  input  logic             i_M_TX_Ready,
  input  logic             i_M_RX_DV,
  input  logic [7:0]       i_M_RX_Byte,
  output logic             o_SPI_CS_n
);

  localparam int MAX_SH   = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int MAX_CLKS = (MAX_SH > CS_GAP_CLKS) ? MAX_SH : CS_GAP_CLKS;
  localparam int CNT_W    = $clog2(MAX_CLKS + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, FETCH, WAIT_RX, DELIVER, HOLD, GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             abort_pending_q, abort_pending_d;
  logic             cs_n_q, cs_n_d;
  logic             m_tx_dv_q, m_tx_dv_d;
  logic [7:0]       m_tx_byte_q, m_tx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             abort_now;
  logic             tx_hs;
  logic [LEN_W-1:0] len_clamped;

  // A same-cycle abort already counts, so it can block the TX handshake it coincides with.
  assign abort_now   = abort_pending_q | (i_Abort & (state_q != IDLE) & (state_q != GAP));
  assign o_Tx_Ready  = (state_q == FETCH) & i_M_TX_Ready & ~abort_now;
  assign tx_hs       = o_Tx_Ready & i_Tx_Valid;
  assign len_clamped = (i_Cmd_Len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_Cmd_Len;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_W'(1);
    remaining_d     = remaining_q;
    abort_pending_d = abort_now;
    cs_n_d          = cs_n_q;
    m_tx_dv_d       = 1'b0;
    m_tx_byte_d     = m_tx_byte_q;
    rx_valid_d      = rx_valid_q;
    rx_data_d       = rx_data_q;
    done_d          = 1'b0;
    aborted_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_Cmd_Valid) begin
          if (i_Cmd_Len == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = len_clamped;
            cs_n_d      = 1'b0;
            cnt_d       = '0;
            state_d     = SETUP;
          end
        end
      end
      SETUP: begin
        if (abort_now) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(CS_SETUP_CLKS - 1)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (abort_now) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (tx_hs) begin
          m_tx_byte_d = i_Tx_Data;
          m_tx_dv_d   = 1'b1;
          state_d     = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (i_M_RX_DV) begin
          if (abort_now) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            rx_data_d  = i_M_RX_Byte;
            rx_valid_d = 1'b1;
            state_d    = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (i_Rx_Ready) begin
          rx_valid_d  = 1'b0;
          remaining_d = remaining_q - LEN_W'(1);
          if ((remaining_q == LEN_W'(1)) || abort_now) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end else if (abort_now) begin
          rx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD_CLKS - 1)) begin
          cs_n_d          = 1'b1;
          done_d          = 1'b1;
          aborted_d       = abort_now;
          abort_pending_d = 1'b0;
          cnt_d           = '0;
          state_d         = GAP;
        end
      end
      GAP: begin
        abort_pending_d = 1'b0;
        if (cnt_q == CNT_W'(CS_GAP_CLKS - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      remaining_q     <= '0;
      abort_pending_q <= 1'b0;
      cs_n_q          <= 1'b1;
      m_tx_dv_q       <= 1'b0;
      m_tx_byte_q     <= 8'h00;
      rx_valid_q      <= 1'b0;
      rx_data_q       <= 8'h00;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      remaining_q     <= remaining_d;
      abort_pending_q <= abort_pending_d;
      cs_n_q          <= cs_n_d;
      m_tx_dv_q       <= m_tx_dv_d;
      m_tx_byte_q     <= m_tx_byte_d;
      rx_valid_q      <= rx_valid_d;
      rx_data_q       <= rx_data_d;
      done_q          <= done_d;
      aborted_q       <= aborted_d;
    end
  end

  assign o_Cmd_Ready = (state_q == IDLE);
  assign o_Busy      = (state_q != IDLE);
  assign o_Done      = done_q;
  assign o_Aborted   = aborted_q;
  assign o_M_TX_Byte = m_tx_byte_q;
  assign o_M_TX_DV   = m_tx_dv_q;
  assign o_Rx_Data   = rx_data_q;
  assign o_Rx_Valid  = rx_valid_q;
  assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: queued expectations, a loopback master model
// and a monitor that checks every DUT output event on the falling clock edge.
module tb_spi_xfer_ctrl;

  localparam int MAX_BYTES = 16;
  localparam int GAP_CLKS  = 2;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);

  logic             i_Clk = 1'b0;
  logic             i_Rst;
  logic             i_Cmd_Valid;
  logic [LEN_W-1:0] i_Cmd_Len;
  logic             o_Cmd_Ready;
  logic             i_Abort;
  logic [7:0]       i_Tx_Data;
  logic             i_Tx_Valid;
  logic             o_Tx_Ready;
  logic [7:0]       o_Rx_Data;
  logic             o_Rx_Valid;
  logic             i_Rx_Ready;
  logic             o_Busy;
  logic             o_Done;
  logic             o_Aborted;
  logic [7:0]       o_M_TX_Byte;
  logic             o_M_TX_DV;
  logic             i_M_TX_Ready;
  logic             i_M_RX_DV;
  logic [7:0]       i_M_RX_Byte;
  logic             o_SPI_CS_n;

  spi_xfer_ctrl #(
    .MAX_BYTES(MAX_BYTES), .CS_SETUP_CLKS(2), .CS_HOLD_CLKS(2), .CS_GAP_CLKS(GAP_CLKS)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_Cmd_Valid(i_Cmd_Valid), .i_Cmd_Len(i_Cmd_Len), .o_Cmd_Ready(o_Cmd_Ready),
    .i_Abort(i_Abort),
    .i_Tx_Data(i_Tx_Data), .i_Tx_Valid(i_Tx_Valid), .o_Tx_Ready(o_Tx_Ready),
    .o_Rx_Data(o_Rx_Data), .o_Rx_Valid(o_Rx_Valid), .i_Rx_Ready(i_Rx_Ready),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Aborted(o_Aborted),
    .o_M_TX_Byte(o_M_TX_Byte), .o_M_TX_DV(o_M_TX_DV), .i_M_TX_Ready(i_M_TX_Ready),
    .i_M_RX_DV(i_M_RX_DV), .i_M_RX_Byte(i_M_RX_Byte),
    .o_SPI_CS_n(o_SPI_CS_n)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct { logic [7:0] data; int dly; } feed_t;
  typedef struct { bit ab; int ndv; } done_t;

  feed_t      feed_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] mtx_q[$];
  done_t      done_q[$];
  logic [7:0] pb[$];

  int  n_vec = 0;
  int  n_err = 0;
  int  dv_total = 0;
  int  first_dly = 0;
  bit  tx_hs = 0;
  bit  flush = 0;
  bit  force_bp = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: sample just before the rising edge.
  initial begin
    int dv_cnt = 0;
    int cs_hi = 0;
    bit have_prev = 0;
    logic [7:0] prev_data = 8'h00;
    done_t d;
    forever begin
      @(negedge i_Clk);
      tx_hs = i_Tx_Valid & o_Tx_Ready;
      if (i_Rst) begin
        dv_cnt = 0;
        have_prev = 0;
        cs_hi = 0;
        continue;
      end
      if (o_M_TX_DV) begin
        dv_cnt++;
        dv_total++;
        if (mtx_q.size() == 0) check("unexpected_m_tx_dv", 1, 0);
        else check("m_tx_byte", o_M_TX_Byte, mtx_q.pop_front());
        check("cs_low_at_dv", o_SPI_CS_n, 0);
        check("no_rx_valid_at_dv", o_Rx_Valid, 0);
      end
      if (have_prev && o_Rx_Valid) check("rx_data_stable", o_Rx_Data, prev_data);
      have_prev = o_Rx_Valid & ~i_Rx_Ready;
      prev_data = o_Rx_Data;
      if (o_Rx_Valid && i_Rx_Ready) begin
        if (rx_q.size() == 0) check("unexpected_rx", 1, 0);
        else check("rx_data", o_Rx_Data, rx_q.pop_front());
      end
      if (o_Done) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          d = done_q.pop_front();
          check("aborted_flag", o_Aborted, d.ab);
          check("dv_count", dv_cnt, d.ndv);
          check("cs_high_at_done", o_SPI_CS_n, 1);
        end
        dv_cnt = 0;
      end else if (o_Aborted) begin
        check("aborted_without_done", 1, 0);
      end
      if (o_SPI_CS_n) cs_hi++;
      else begin
        if (cs_hi > 0) check("cs_gap", (cs_hi >= GAP_CLKS) ? 1 : 0, 1);
        cs_hi = 0;
      end
    end
  end

  // TX byte source with per-byte presentation delay.
  initial begin
    int wcnt = -1;
    i_Tx_Valid = 0;
    i_Tx_Data  = 8'h00;
    forever begin
      @(posedge i_Clk); #1;
      if (flush) begin
        feed_q.delete();
        i_Tx_Valid = 0;
        wcnt = -1;
        continue;
      end
      if (tx_hs) begin
        void'(feed_q.pop_front());
        i_Tx_Valid = 0;
        wcnt = -1;
      end
      if (!i_Tx_Valid && feed_q.size() > 0) begin
        if (wcnt < 0) wcnt = feed_q[0].dly;
        if (wcnt == 0) begin
          i_Tx_Valid = 1;
          i_Tx_Data  = feed_q[0].data;
          wcnt = -1;
        end else wcnt--;
      end
    end
  end

  // RX sink: random ready, or a forced 10-cycle stall on the first presented byte.
  initial begin
    int bp_cnt = 0;
    i_Rx_Ready = 1;
    forever begin
      @(posedge i_Clk); #1;
      if (force_bp) begin
        if (o_Rx_Valid) begin
          if (bp_cnt < 10) begin i_Rx_Ready = 0; bp_cnt++; end
          else begin i_Rx_Ready = 1; force_bp = 0; bp_cnt = 0; end
        end else i_Rx_Ready = 0;
      end else i_Rx_Ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Loopback master: echoes each byte after 1..5 cycles; stray RX strobes while idle.
  initial begin
    logic [7:0] b;
    i_M_TX_Ready = 1;
    i_M_RX_DV    = 0;
    i_M_RX_Byte  = 8'h00;
    forever begin
      @(posedge i_Clk); #1;
      i_M_RX_DV = 0;
      if (o_M_TX_DV) begin
        b = o_M_TX_Byte;
        i_M_TX_Ready = 0;
        repeat ($urandom_range(1, 5)) @(posedge i_Clk);
        #1;
        i_M_RX_DV    = 1;
        i_M_RX_Byte  = b;
        i_M_TX_Ready = 1;
      end else if (!o_Busy && $urandom_range(0, 7) == 0) begin
        i_M_RX_DV   = 1;
        i_M_RX_Byte = 8'($urandom);
      end
    end
  end

  // Expected behaviour of a normal transaction: min(len, MAX_BYTES) bytes echoed in order.
  task automatic queue_txn(input int len);
    int lc;
    feed_t f;
    done_t d;
    lc = (len > MAX_BYTES) ? MAX_BYTES : len;
    for (int i = 0; i < lc; i++) begin
      f.data = (i < pb.size()) ? pb[i] : 8'($urandom);
      f.dly  = (i == 0) ? first_dly : $urandom_range(0, 3);
      feed_q.push_back(f);
      rx_q.push_back(f.data);
      mtx_q.push_back(f.data);
    end
    d.ab = 0;
    d.ndv = lc;
    done_q.push_back(d);
    pb.delete();
  endtask

  task automatic issue_cmd(input int len);
    int t = 0;
    while (t < 2000) begin
      @(posedge i_Clk); #1;
      if (o_Cmd_Ready) break;
      t++;
    end
    check("cmd_ready_timeout", (t < 2000) ? 1 : 0, 1);
    check("busy_vs_ready", o_Busy, !o_Cmd_Ready);
    $display("cmd len=%0d at %0t", len, $time);
    i_Cmd_Valid = 1;
    i_Cmd_Len   = LEN_W'(len);
    @(posedge i_Clk); #1;
    i_Cmd_Valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (t < 3000 && !(o_Cmd_Ready && done_q.size() == 0 && rx_q.size() == 0)) begin
      @(posedge i_Clk); #1;
      t++;
    end
    check("idle_timeout", (t < 3000) ? 1 : 0, 1);
  endtask

  task automatic wait_dv(input int n);
    int c = 0;
    int t = 0;
    while (c < n && t < 2000) begin
      @(posedge i_Clk); #1;
      if (o_M_TX_DV) c++;
      t++;
    end
    check("dv_wait_timeout", (t < 2000) ? 1 : 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},     o_SPI_CS_n, 1);
    check({tag, "_m_tx_dv"},  o_M_TX_DV, 0);
    check({tag, "_m_tx_byte"}, o_M_TX_Byte, 0);
    check({tag, "_rx_valid"}, o_Rx_Valid, 0);
    check({tag, "_rx_data"},  o_Rx_Data, 0);
    check({tag, "_done"},     o_Done, 0);
    check({tag, "_aborted"},  o_Aborted, 0);
    check({tag, "_busy"},     o_Busy, 0);
  endtask

  initial begin
    int saved;
    feed_t f;
    done_t d;
    i_Rst = 1;
    i_Cmd_Valid = 0;
    i_Cmd_Len = '0;
    i_Abort = 0;
    repeat (3) @(posedge i_Clk);
    #2;
    check_reset_outputs("reset");
    check("reset_cmd_ready", o_Cmd_Ready, 1);
    i_Rst = 0;

    // Loopback C1,A2,B3
    pb.push_back(8'hC1); pb.push_back(8'hA2); pb.push_back(8'hB3);
    queue_txn(3);
    issue_cmd(3);
    check("cs_falls_after_accept", o_SPI_CS_n, 0);
    wait_idle();

    // Zero length: done next cycle, no CS activity
    queue_txn(0);
    issue_cmd(0);
    check("zero_len_done", o_Done, 1);
    check("zero_len_cs", o_SPI_CS_n, 1);
    check("zero_len_busy", o_Busy, 0);
    wait_idle();

    // RX backpressure on first byte
    force_bp = 1;
    queue_txn(2);
    issue_cmd(2);
    saved = 0;
    while (!o_Rx_Valid && saved < 500) begin @(posedge i_Clk); #1; saved++; end
    saved = dv_total;
    repeat (8) @(posedge i_Clk);
    #1;
    check("bp_no_second_dv", dv_total, saved);
    check("bp_rx_valid_held", o_Rx_Valid, 1);
    wait_idle();

    // TX starvation: first byte offered 20 cycles late
    first_dly = 20;
    queue_txn(2);
    first_dly = 0;
    saved = dv_total;
    issue_cmd(2);
    repeat (15) @(posedge i_Clk);
    #1;
    check("starve_no_dv", dv_total, saved);
    check("starve_cs_low", o_SPI_CS_n, 0);
    check("starve_busy", o_Busy, 1);
    wait_idle();

    // Abort while waiting on byte 2's RX: byte 2 discarded
    for (int i = 0; i < 2; i++) begin
      f.data = 8'($urandom);
      f.dly  = $urandom_range(0, 3);
      feed_q.push_back(f);
      mtx_q.push_back(f.data);
      if (i == 0) rx_q.push_back(f.data);
    end
    d.ab = 1; d.ndv = 2;
    done_q.push_back(d);
    issue_cmd(4);
    wait_dv(2);
    i_Abort = 1;
    @(posedge i_Clk); #1;
    i_Abort = 0;
    wait_idle();
    queue_txn(1);
    issue_cmd(1);
    wait_idle();

    // Abort during CS setup: no bytes issued
    d.ab = 1; d.ndv = 0;
    done_q.push_back(d);
    issue_cmd(2);
    i_Abort = 1;
    @(posedge i_Clk); #1;
    i_Abort = 0;
    wait_idle();

    // Reset while in WAIT_RX
    queue_txn(3);
    issue_cmd(3);
    wait_dv(1);
    i_Rst = 1;
    flush = 1;
    @(posedge i_Clk); #2;
    check_reset_outputs("midrst");
    rx_q.delete(); mtx_q.delete(); done_q.delete();
    flush = 0;
    i_Rst = 0;
    @(posedge i_Clk); #2;
    check("midrst_cmd_ready", o_Cmd_Ready, 1);
    repeat (8) @(posedge i_Clk);

    // Random back-to-back commands, including lengths above MAX_BYTES
    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(0, 20);
      queue_txn(len);
      issue_cmd(len);
    end
    wait_idle();
    repeat (5) @(posedge i_Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge i_Clk);
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
